// File: rtl/williams2_pkg.sv
// Shared types and default constants for the williams2 ROM download path.
package williams2_pkg;

    // Loader FSM states; the encoding is also exported on the state debug port.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        HOLD  = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } loader_state_t;

    // ioctl_index that selects the game ROM set.
    localparam logic [15:0] DEFAULT_ROM_INDEX = 16'd0;

    // Exact size of the williams2 ROM image in bytes.
    localparam logic [18:0] DEFAULT_ROM_BYTES = 19'd327680;

endpackage

// File: rtl/williams2_dn_filter.sv
// Decodes ioctl writes into accepted / out-of-range and registers the
// accepted ones towards the core with exactly one cycle of latency.
module williams2_dn_filter
    import williams2_pkg::*;
#(
    parameter int              ADDR_W    = 19,
    parameter logic [ADDR_W-1:0] ROM_BYTES = DEFAULT_ROM_BYTES,
    parameter logic [15:0]     ROM_INDEX = DEFAULT_ROM_INDEX
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              download_i,
    input  logic              wr_i,
    input  logic [24:0]       addr_i,
    input  logic [7:0]        dout_i,
    input  logic [15:0]       index_i,
    output logic              match_o,
    output logic              accept_o,
    output logic              oor_hit_o,
    output logic [ADDR_W-1:0] dn_addr_o,
    output logic [7:0]        dn_data_o,
    output logic              dn_wr_o
);

    // Full 25-bit limit so high address bits can never alias into range.
    logic [24:0]       rom_limit;
    logic              in_range;
    logic [ADDR_W-1:0] dn_addr_q, dn_addr_d;
    logic [7:0]        dn_data_q, dn_data_d;
    logic              dn_wr_q, dn_wr_d;

    assign rom_limit = 25'(ROM_BYTES);
    assign in_range  = addr_i < rom_limit;
    assign match_o   = download_i & (index_i == ROM_INDEX);
    assign accept_o  = match_o & wr_i & in_range;
    assign oor_hit_o = match_o & wr_i & ~in_range;

    // Next output values: capture on accept, otherwise hold addr/data.
    always_comb begin
        dn_addr_d = dn_addr_q;
        dn_data_d = dn_data_q;
        dn_wr_d   = accept_o;
        if (accept_o) begin
            dn_addr_d = addr_i[ADDR_W-1:0];
            dn_data_d = dout_i;
        end
    end

    // Output register towards the core.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dn_addr_q <= '0;
            dn_data_q <= '0;
            dn_wr_q   <= 1'b0;
        end else begin
            dn_addr_q <= dn_addr_d;
            dn_data_q <= dn_data_d;
            dn_wr_q   <= dn_wr_d;
        end
    end

    assign dn_addr_o = dn_addr_q;
    assign dn_data_o = dn_data_q;
    assign dn_wr_o   = dn_wr_q;

endmodule

// File: rtl/williams2_rom_loader.sv
// Bridges the HPS ioctl download to the williams2 core: filters writes,
// counts and checksums them, and sequences the core reset around a load.
module williams2_rom_loader
    import williams2_pkg::*;
#(
    parameter logic [15:0]       ROM_INDEX   = DEFAULT_ROM_INDEX,
    parameter int                ADDR_W      = 19,
    parameter logic [ADDR_W-1:0] ROM_BYTES   = DEFAULT_ROM_BYTES,
    parameter int                HOLD_CYCLES = 16
) (
    input  logic              clock_12,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [15:0]       ioctl_index,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic              dn_wr,
    output logic              core_reset,
    output logic              rom_ready,
    output logic              rom_error,
    output logic              oor_seen,
    output logic [ADDR_W:0]   byte_count,
    output logic [7:0]        checksum,
    output logic [2:0]        state_dbg
);

    localparam int              HC_W      = $clog2(HOLD_CYCLES + 1);
    localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYCLES);
    localparam logic [HC_W-1:0] HC_ONE    = HC_W'(1);
    localparam logic [ADDR_W:0] ROM_COUNT = {1'b0, ROM_BYTES};
    localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic match, accept, oor_hit;
    logic match_q, match_rise, match_fall;

    loader_state_t   state_q, state_d;
    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [ADDR_W:0] byte_count_q, byte_count_d;
    logic [7:0]      checksum_q, checksum_d;
    logic            oor_q, oor_d;

    williams2_dn_filter #(
        .ADDR_W   (ADDR_W),
        .ROM_BYTES(ROM_BYTES),
        .ROM_INDEX(ROM_INDEX)
    ) u_filter (
        .clk_i     (clock_12),
        .rst_i     (reset),
        .download_i(ioctl_download),
        .wr_i      (ioctl_wr),
        .addr_i    (ioctl_addr),
        .dout_i    (ioctl_dout),
        .index_i   (ioctl_index),
        .match_o   (match),
        .accept_o  (accept),
        .oor_hit_o (oor_hit),
        .dn_addr_o (dn_addr),
        .dn_data_o (dn_data),
        .dn_wr_o   (dn_wr)
    );

    assign match_rise = match & ~match_q;
    assign match_fall = ~match & match_q;

    // Next-state, hold counter and accumulators; a match rising edge wins over everything.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        byte_count_d = byte_count_q;
        checksum_d   = checksum_q;
        oor_d        = oor_q;

        // A byte in the very first cycle of a download is counted after the clear.
        if (match_rise) begin
            byte_count_d = {{ADDR_W{1'b0}}, accept};
            checksum_d   = accept ? ioctl_dout : 8'h00;
            oor_d        = oor_hit;
        end else begin
            if (accept) begin
                if (byte_count_q != '1) begin
                    byte_count_d = byte_count_q + CNT_ONE;
                end
                checksum_d = checksum_q + ioctl_dout;
            end
            if (oor_hit) begin
                oor_d = 1'b1;
            end
        end

        if (match_rise) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                LOAD: begin
                    if (match_fall) begin
                        if (byte_count_d == ROM_COUNT) begin
                            state_d    = HOLD;
                            hold_cnt_d = HOLD_LOAD;
                        end else begin
                            state_d = ERROR;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt_q <= HC_ONE) begin
                        state_d = RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HC_ONE;
                    end
                end
                RUN:     state_d = RUN;
                ERROR:   state_d = ERROR;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, counters and the match edge detector.
    always_ff @(posedge clock_12 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            byte_count_q <= '0;
            checksum_q   <= '0;
            oor_q        <= 1'b0;
            match_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            byte_count_q <= byte_count_d;
            checksum_q   <= checksum_d;
            oor_q        <= oor_d;
            match_q      <= match;
        end
    end

    // Status decodes from the registered state, so core_reset rises with LOAD.
    assign core_reset = (state_q != RUN);
    assign rom_ready  = (state_q == RUN);
    assign rom_error  = (state_q == ERROR);
    assign oor_seen   = oor_q;
    assign byte_count = byte_count_q;
    assign checksum   = checksum_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_williams2_rom_loader.sv
// Bench for williams2_rom_loader with a small ROM (16 bytes) and short hold (4).
module tb_williams2_rom_loader;
    import williams2_pkg::*;

    localparam int ADDR_W = 19;
    localparam int NBYTES = 16;
    localparam int HOLDC  = 4;
    localparam int EW     = 32 + ADDR_W + 8;

    // Handshake: dn_wr is a one-cycle strobe; dn_addr/dn_data are valid while it is high.

    logic              clock_12 = 1'b0;
    logic              reset;
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [15:0]       ioctl_index;
    logic [ADDR_W-1:0] dn_addr;
    logic [7:0]        dn_data;
    logic              dn_wr;
    logic              core_reset, rom_ready, rom_error, oor_seen;
    logic [ADDR_W:0]   byte_count;
    logic [7:0]        checksum;
    logic [2:0]        state_dbg;

    williams2_rom_loader #(
        .ROM_INDEX  (16'd0),
        .ADDR_W     (ADDR_W),
        .ROM_BYTES  (19'd16),
        .HOLD_CYCLES(HOLDC)
    ) dut (
        .clock_12      (clock_12),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_index   (ioctl_index),
        .dn_addr       (dn_addr),
        .dn_data       (dn_data),
        .dn_wr         (dn_wr),
        .core_reset    (core_reset),
        .rom_ready     (rom_ready),
        .rom_error     (rom_error),
        .oor_seen      (oor_seen),
        .byte_count    (byte_count),
        .checksum      (checksum),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock_12 = ~clock_12;

    int unsigned cyc = 0;
    always @(posedge clock_12) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    int checks = 0;
    int errors = 0;
    int m_count;
    int m_sum;
    bit m_oor;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock_12) begin
        if (dn_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dn_wr_unexpected: got addr 0x%0h data 0x%0h expected no write", dn_addr, dn_data);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("dn_wr_cycle", cyc, e[EW-1:ADDR_W+8]);
                check("dn_addr", 32'(dn_addr), 32'(e[ADDR_W+7:8]));
                check("dn_data", 32'(dn_data), 32'(e[7:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock_12);
        #1;
    endtask

    task automatic start_dl(input logic [15:0] idx);
        ioctl_download = 1'b1;
        ioctl_index    = idx;
        if (idx == 16'd0) begin
            m_count = 0;
            m_sum   = 0;
            m_oor   = 1'b0;
        end
        tick();
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (ioctl_download && ioctl_index == 16'd0) begin
            if (a < NBYTES) begin
                exp_q.push_back({cyc + 32'd1, a[ADDR_W-1:0], d});
                m_count++;
                m_sum = (m_sum + d) % 256;
            end else begin
                m_oor = 1'b1;
            end
        end
        tick();
        ioctl_wr = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic full_load(input bit fixed_data);
        start_dl(16'd0);
        for (int i = 0; i < NBYTES; i++) begin
            wr_byte(25'(i), fixed_data ? 8'(i + 1) : 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic check_counters(input string tag);
        @(negedge clock_12);
        check({tag, "_byte_count"}, 32'(byte_count), 32'(m_count));
        check({tag, "_checksum"}, 32'(checksum), 32'(m_sum));
        check({tag, "_oor_seen"}, 32'(oor_seen), 32'(m_oor));
    endtask

    // Counts cycles of core_reset high starting one edge after the download drops.
    task automatic expect_hold(input string tag);
        int n;
        n = 0;
        end_dl();
        tick();
        for (int i = 0; i < 50; i++) begin
            @(negedge clock_12);
            if (core_reset !== 1'b1) break;
            n++;
        end
        check({tag, "_hold_cycles"}, n, HOLDC);
        check({tag, "_rom_ready"}, 32'(rom_ready), 1);
        check({tag, "_rom_error"}, 32'(rom_error), 0);
        check({tag, "_state_run"}, 32'(state_dbg), 32'(RUN));
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dn_wr"}, 32'(dn_wr), 0);
        check({tag, "_dn_addr"}, 32'(dn_addr), 0);
        check({tag, "_dn_data"}, 32'(dn_data), 0);
        check({tag, "_core_reset"}, 32'(core_reset), 1);
        check({tag, "_rom_ready"}, 32'(rom_ready), 0);
        check({tag, "_rom_error"}, 32'(rom_error), 0);
        check({tag, "_oor_seen"}, 32'(oor_seen), 0);
        check({tag, "_byte_count"}, 32'(byte_count), 0);
        check({tag, "_checksum"}, 32'(checksum), 0);
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    // ---------------- test sequence ----------------
    bit watch_run = 1'b0;
    int run_glitch = 0;
    always @(negedge clock_12) if (watch_run && core_reset !== 1'b0) run_glitch++;

    initial begin
        int n;
        int saved_count, saved_sum;
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        ioctl_index = '0;
        m_count = 0; m_sum = 0; m_oor = 1'b0;
        repeat (3) tick();
        check_reset_values("por");
        reset = 1'b0;
        tick();

        // Full 16-byte load with known data: checksum 1+..+16 = 0x88.
        full_load(1'b1);
        check_counters("full");
        check("full_checksum_const", 32'(checksum), 32'h88);
        check("full_core_reset_in_load", 32'(core_reset), 1);
        expect_hold("full");

        // Short load of 15 bytes ends in ERROR and never releases the core.
        start_dl(16'd0);
        for (int i = 0; i < NBYTES - 1; i++) wr_byte(25'(i), 8'($urandom_range(0, 255)));
        check_counters("short");
        end_dl();
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock_12);
            if (core_reset === 1'b1) n++;
        end
        check("short_core_reset_held", n, 1000);
        check("short_rom_error", 32'(rom_error), 1);
        check("short_rom_ready", 32'(rom_ready), 0);
        check("short_state", 32'(state_dbg), 32'(ERROR));
        tick();

        // Out-of-range writes are dropped but flagged; the load still succeeds.
        start_dl(16'd0);
        for (int i = 0; i < NBYTES; i++) begin
            if (i == 5) wr_byte(25'd16, 8'hAA);
            if (i == 11) wr_byte(25'h1000010, 8'h55);
            wr_byte(25'(i), 8'($urandom_range(0, 255)));
        end
        check_counters("oor");
        check("oor_flag", 32'(oor_seen), 1);
        expect_hold("oor");
        check("oor_flag_after_run", 32'(oor_seen), 1);

        // Download to another index while running is ignored.
        @(negedge clock_12);
        saved_count = 32'(byte_count);
        saved_sum   = 32'(checksum);
        tick();
        watch_run = 1'b1;
        start_dl(16'd1);
        for (int i = 0; i < 6; i++) wr_byte(25'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end_dl();
        repeat (3) tick();
        watch_run = 1'b0;
        check("other_core_reset_glitch", run_glitch, 0);
        @(negedge clock_12);
        check("other_byte_count", 32'(byte_count), saved_count);
        check("other_checksum", 32'(checksum), saved_sum);
        check("other_state", 32'(state_dbg), 32'(RUN));
        tick();

        // Restart two cycles into HOLD.
        full_load(1'b0);
        end_dl();
        tick();
        tick();
        check("hold_entered", 32'(state_dbg), 32'(HOLD));
        ioctl_download = 1'b1;
        ioctl_index    = 16'd0;
        m_count = 0; m_sum = 0; m_oor = 1'b0;
        tick();
        check("restart_state", 32'(state_dbg), 32'(LOAD));
        check("restart_core_reset", 32'(core_reset), 1);
        check("restart_rom_ready", 32'(rom_ready), 0);
        check_counters("restart");
        for (int i = 0; i < NBYTES; i++) wr_byte(25'(i), 8'($urandom_range(0, 255)));
        check_counters("restart_full");
        expect_hold("restart");

        // Asynchronous reset in the middle of a load.
        start_dl(16'd0);
        for (int i = 0; i < 8; i++) wr_byte(25'(i), 8'($urandom_range(0, 255)));
        repeat (2) tick();
        check_counters("mid");
        @(posedge clock_12);
        #3;
        reset = 1'b1;
        ioctl_download = 1'b0;
        #1;
        check_reset_values("async");
        tick();
        reset = 1'b0;
        tick();
        full_load(1'b0);
        check_counters("post_reset");
        expect_hold("post_reset");

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
